// File: rtl/dp_types_pkg.sv
// rtl/dp_types_pkg.sv - shared datapath types for the pipelined MIPS core
package dp_types_pkg;

    typedef logic [31:0] word_t;

    // Branch/jump resolution sent back from EX to the fetch predictor
    typedef struct packed {
        logic  valid;
        logic  taken;
        word_t pc;
        word_t target;
    } pred_upd_t;

    // IF/ID latch; the prediction travels with the instruction so EX can spot mispredicts
    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  pred_taken;
        word_t pred_target;
    } IF_ID_t;

endpackage

// File: rtl/branch_pc_predictor_btb_table.sv
// rtl/branch_pc_predictor_btb_table.sv - direct-mapped BTB storage with flush
module btb_table #(
    parameter int ENTRIES  = 16,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 26,
    parameter int WORD_W   = 32,
    parameter int CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0] CTR_RST = '0
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                flush,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [WORD_W-1:0]   rd_target,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic [IDX_W-1:0]    wr_idx,
    output logic                wr_cur_valid,
    output logic [TAG_W-1:0]    wr_cur_tag,
    output logic [WORD_W-1:0]   wr_cur_target,
    output logic [CTR_BITS-1:0] wr_cur_ctr,
    input  logic                wr_en,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [WORD_W-1:0]   wr_target,
    input  logic [CTR_BITS-1:0] wr_ctr
);

    logic [ENTRIES-1:0]  valid_arr;
    logic [CTR_BITS-1:0] ctr_arr    [ENTRIES];
    logic [TAG_W-1:0]    tag_arr    [ENTRIES];
    logic [WORD_W-1:0]   target_arr [ENTRIES];

    // Lookup port and the read half of the read-modify-write update port
    always_comb begin
        rd_valid      = valid_arr[rd_idx];
        rd_tag        = tag_arr[rd_idx];
        rd_target     = target_arr[rd_idx];
        rd_ctr        = ctr_arr[rd_idx];
        wr_cur_valid  = valid_arr[wr_idx];
        wr_cur_tag    = tag_arr[wr_idx];
        wr_cur_target = target_arr[wr_idx];
        wr_cur_ctr    = ctr_arr[wr_idx];
    end

    // Valid bits and counters have a defined reset; flush beats a same-cycle write
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_arr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_arr[i] <= CTR_RST;
            end
        end else if (flush) begin
            valid_arr <= '0;
        end else if (wr_en) begin
            valid_arr[wr_idx] <= 1'b1;
            ctr_arr[wr_idx]   <= wr_ctr;
        end
    end

    // Tag and target are don't-care until their entry becomes valid
    always_ff @(posedge CLK) begin
        if (nRST && wr_en && !flush) begin
            tag_arr[wr_idx]    <= wr_tag;
            target_arr[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_pc_predictor.sv
// rtl/branch_pc_predictor.sv - fetch PC register with BTB-driven next-PC prediction
module branch_pc_predictor
    import dp_types_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int WORD_W      = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              stall,
    input  logic              halt,
    input  logic              flush_btb,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              upd_valid,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] pc4_o,
    output logic              pred_taken_o,
    output logic [WORD_W-1:0] pred_target_o
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = WORD_W - IDX_W - 2;
    localparam logic [WORD_W-1:0]   FOUR       = WORD_W'(4);
    localparam logic [CTR_BITS-1:0] CTR_ONE    = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_ONE << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_N = CTR_WEAK_T - CTR_ONE;

    logic [WORD_W-1:0]   pc;
    logic                lk_valid;
    logic [TAG_W-1:0]    lk_tag;
    logic [WORD_W-1:0]   lk_target;
    logic [CTR_BITS-1:0] lk_ctr;
    logic                cur_valid;
    logic [TAG_W-1:0]    cur_tag;
    logic [WORD_W-1:0]   cur_target;
    logic [CTR_BITS-1:0] cur_ctr;
    logic [CTR_BITS-1:0] ctr_next;
    logic                upd_hit;
    logic                wr_en;
    logic [CTR_BITS-1:0] wr_ctr;
    logic [WORD_W-1:0]   wr_target;
    logic [1:0]          unused_upd_lsb;

    assign unused_upd_lsb = upd_pc[1:0];

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .WORD_W  (WORD_W),
        .CTR_BITS(CTR_BITS),
        .CTR_RST (CTR_WEAK_N)
    ) u_btb (
        .CLK          (CLK),
        .nRST         (nRST),
        .flush        (flush_btb),
        .rd_idx       (pc[IDX_W+1:2]),
        .rd_valid     (lk_valid),
        .rd_tag       (lk_tag),
        .rd_target    (lk_target),
        .rd_ctr       (lk_ctr),
        .wr_idx       (upd_pc[IDX_W+1:2]),
        .wr_cur_valid (cur_valid),
        .wr_cur_tag   (cur_tag),
        .wr_cur_target(cur_target),
        .wr_cur_ctr   (cur_ctr),
        .wr_en        (wr_en),
        .wr_tag       (upd_pc[WORD_W-1:IDX_W+2]),
        .wr_target    (wr_target),
        .wr_ctr       (wr_ctr)
    );

    // Lookup on the current fetch PC; a taken prediction needs a tag hit and counter MSB
    always_comb begin
        pc_o          = pc;
        pc4_o         = pc + FOUR;
        pred_taken_o  = lk_valid && (lk_tag == pc[WORD_W-1:IDX_W+2]) && lk_ctr[CTR_BITS-1];
        pred_target_o = pred_taken_o ? lk_target : pc4_o;
    end

    // Resolution update: saturate on a hit, allocate weakly-taken on a taken miss
    always_comb begin
        upd_hit  = cur_valid && (cur_tag == upd_pc[WORD_W-1:IDX_W+2]);
        ctr_next = cur_ctr;
        if (upd_taken) begin
            if (cur_ctr != CTR_MAX) ctr_next = cur_ctr + CTR_ONE;
        end else begin
            if (cur_ctr != '0) ctr_next = cur_ctr - CTR_ONE;
        end
        wr_en     = upd_valid && (upd_hit || upd_taken);
        wr_ctr    = upd_hit ? ctr_next : CTR_WEAK_T;
        wr_target = upd_taken ? upd_target : cur_target;
    end

    // Fetch PC: halt, then redirect, then normal advance along the prediction
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc <= PC_INIT;
        end else if (halt) begin
            pc <= pc;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (ihit && !stall) begin
            pc <= pred_target_o;
        end
    end

endmodule

// File: tb/tb_branch_pc_predictor.sv
// tb/tb_branch_pc_predictor.sv - scoreboard bench for branch_pc_predictor
module tb_branch_pc_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, halt, flush_btb, redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic [31:0] pc_o, pc4_o, pred_target_o;
    logic        pred_taken_o;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    branch_pc_predictor dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .stall        (stall),
        .halt         (halt),
        .flush_btb    (flush_btb),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .pc_o         (pc_o),
        .pc4_o        (pc4_o),
        .pred_taken_o (pred_taken_o),
        .pred_target_o(pred_target_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, compare against the oldest expectation
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pc_o", pc_o, e.pc);
            chk("pc4_o", pc4_o, e.pc + 32'd4);
            chk("pred_taken_o", {31'd0, pred_taken_o}, {31'd0, e.pt});
            chk("pred_target_o", pred_target_o, e.tgt);
        end
    end

    task automatic clear_inputs();
        ihit = 0; stall = 0; halt = 0; flush_btb = 0; redirect = 0; redirect_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    endtask

    // Record expected outputs for the current cycle, then advance one clock
    task automatic step(input logic [31:0] epc, input logic ept, input logic [31:0] etgt);
        exp_t e;
        e.pc = epc; e.pt = ept; e.tgt = etgt;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        clear_inputs();
    endtask

    task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tg);
        upd_valid = 1; upd_pc = p; upd_taken = t; upd_target = tg;
    endtask

    task automatic redir(input logic [31:0] p);
        redirect = 1; redirect_pc = p;
    endtask

    initial begin
        nRST = 0;
        clear_inputs();
        @(posedge CLK);
        #1;
        // reset state
        step(32'h0, 0, 32'h4);
        step(32'h0, 0, 32'h4);
        nRST = 1;
        // sequential stream
        ihit = 1; step(32'h0, 0, 32'h4);
        ihit = 1; step(32'h4, 0, 32'h8);
        // miss and stall hold at 8
        step(32'h8, 0, 32'hC);
        step(32'h8, 0, 32'hC);
        step(32'h8, 0, 32'hC);
        ihit = 1; stall = 1; step(32'h8, 0, 32'hC);
        ihit = 1; stall = 1; step(32'h8, 0, 32'hC);
        ihit = 1; step(32'h8, 0, 32'hC);
        // allocate 0x10 -> 0x40
        upd(32'h10, 1, 32'h40); step(32'hC, 0, 32'h10);
        ihit = 1; step(32'hC, 0, 32'h10);
        ihit = 1; step(32'h10, 1, 32'h40);
        redir(32'h10); step(32'h40, 0, 32'h44);
        // saturation: 10 -> 11 -> 11 -> 10 -> 01
        upd(32'h10, 1, 32'h40); step(32'h10, 1, 32'h40);
        upd(32'h10, 1, 32'h40); step(32'h10, 1, 32'h40);
        upd(32'h10, 0, 32'h0);  step(32'h10, 1, 32'h40);
        upd(32'h10, 0, 32'h0);  step(32'h10, 1, 32'h40);
        ihit = 1; step(32'h10, 0, 32'h14);
        // alias into idx 4 and flush
        upd(32'h50, 1, 32'h80); step(32'h14, 0, 32'h18);
        redir(32'h10); step(32'h14, 0, 32'h18);
        redir(32'h50); step(32'h10, 0, 32'h14);
        ihit = 1; step(32'h50, 1, 32'h80);
        flush_btb = 1; upd(32'h50, 1, 32'h80); redir(32'h50); step(32'h80, 0, 32'h84);
        ihit = 1; step(32'h50, 0, 32'h54);
        // write visible only on the following cycle
        upd(32'h54, 1, 32'h100); step(32'h54, 0, 32'h58);
        step(32'h54, 1, 32'h100);
        // redirect beats stall and missing ihit
        redir(32'h200); stall = 1; step(32'h54, 1, 32'h100);
        // halt beats redirect; updates still land during halt
        halt = 1; redir(32'h300); ihit = 1; step(32'h200, 0, 32'h204);
        halt = 1; ihit = 1; step(32'h200, 0, 32'h204);
        halt = 1; upd(32'h200, 1, 32'h500); step(32'h200, 0, 32'h204);
        halt = 1; step(32'h200, 1, 32'h500);
        // asynchronous reset mid-run discards the in-flight update
        halt = 1; nRST = 0; upd(32'h0, 1, 32'h900); step(32'h0, 0, 32'h4);
        nRST = 1; step(32'h0, 0, 32'h4);
        step(32'h0, 0, 32'h4);
        // wrap-around
        redir(32'hFFFF_FFFC); step(32'h0, 0, 32'h4);
        ihit = 1; step(32'hFFFF_FFFC, 0, 32'h0);
        step(32'h0, 0, 32'h4);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
